// File: rtl/wfill_pkg.sv
// wfill_pkg: shared state encoding, default sizing and Gray decode for the write-side fill monitor.
package wfill_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        AFULL  = 2'd1,
        FULL   = 2'd2
    } fc_state_e;

    localparam int WFILL_ADDRSIZE_DEF = 4;
    localparam int GRAY_MAX_W         = 16;

    // Decodes the low w bits of g; bits above w are masked so they cannot leak into the result.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g, input int w);
        logic [GRAY_MAX_W-1:0] m;
        logic [GRAY_MAX_W-1:0] b;
        m = g & ((GRAY_MAX_W'(1) << w) - GRAY_MAX_W'(1));
        b = '0;
        b[GRAY_MAX_W-1] = m[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ m[i];
        return b;
    endfunction

endpackage

// File: rtl/wr_fill_monitor_sync2_ff.sv
// sync2_ff: parameterized-width two-flop synchronizer with asynchronous active-low reset.
module sync2_ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            o_q     <= '0;
        end else begin
            r_sync1 <= i_d;
            o_q     <= r_sync1;
        end
    end

endmodule

// File: rtl/wr_fill_monitor.sv
// wr_fill_monitor: syncs the Gray read pointer into wclk_i, derives fill level, almost-full FSM and error flag.
// Define WFILL_WATERMARK_EN to add the peak-fill watermark register behind wm_level_o.
module wr_fill_monitor
    import wfill_pkg::*;
#(
    parameter int ADDRSIZE = WFILL_ADDRSIZE_DEF
) (
    input  logic              wclk_i,
    input  logic              wrst_n_i,
    input  logic [ADDRSIZE:0] rptr_g_i,
    input  logic [ADDRSIZE:0] wbin_i,
    input  logic [ADDRSIZE:0] afull_thresh_i,
    input  logic [ADDRSIZE:0] afull_hyst_i,
    input  logic              wm_clr_i,
    output logic [ADDRSIZE:0] rptr_sync2_wrclk_o,
    output logic [ADDRSIZE:0] rbin_w_o,
    output logic [ADDRSIZE:0] wfill_o,
    output logic [1:0]        fc_state_o,
    output logic              afull_o,
    output logic              level_err_o,
    output logic [ADDRSIZE:0] wm_level_o
);

    localparam int           W     = ADDRSIZE + 1;
    localparam logic [W-1:0] DEPTH = W'(1) << ADDRSIZE;

    logic [W-1:0] w_raw;
    logic [W-1:0] w_rel;
    logic         w_over;
    logic [W-1:0] r_wfill;
    logic         r_err;
    fc_state_e    r_state;
    fc_state_e    w_state_nxt;

    sync2_ff #(.WIDTH(W)) u_rptr_sync (
        .i_clk   (wclk_i),
        .i_rst_n (wrst_n_i),
        .i_d     (rptr_g_i),
        .o_q     (rptr_sync2_wrclk_o)
    );

    assign rbin_w_o = W'(gray2bin(GRAY_MAX_W'(rptr_sync2_wrclk_o), W));
    assign w_raw    = wbin_i - rbin_w_o;
    assign w_over   = w_raw > DEPTH;
    assign w_rel    = (afull_thresh_i > afull_hyst_i) ? afull_thresh_i - afull_hyst_i : '0;

    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) begin
            r_wfill <= '0;
            r_err   <= 1'b0;
        end else begin
            r_wfill <= w_over ? DEPTH : w_raw;
            r_err   <= r_err | w_over;
        end
    end

    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) r_state <= NORMAL;
        else           r_state <= w_state_nxt;
    end

    // AFULL and FULL share the release rule; only NORMAL compares against the raw threshold.
    always_comb begin
        w_state_nxt = r_state;
        if (r_wfill == DEPTH)
            w_state_nxt = FULL;
        else if (r_state == NORMAL)
            w_state_nxt = (afull_thresh_i != '0 && r_wfill >= afull_thresh_i) ? AFULL : NORMAL;
        else
            w_state_nxt = (afull_thresh_i != '0 && r_wfill >= w_rel) ? AFULL : NORMAL;
    end

    assign wfill_o     = r_wfill;
    assign fc_state_o  = r_state;
    assign afull_o     = r_state != NORMAL;
    assign level_err_o = r_err;

`ifdef WFILL_WATERMARK_EN
    logic [W-1:0] r_wm;

    always_ff @(posedge wclk_i or negedge wrst_n_i) begin
        if (!wrst_n_i) r_wm <= '0;
        else           r_wm <= (wm_clr_i || r_wfill > r_wm) ? r_wfill : r_wm;
    end

    assign wm_level_o = r_wm;
`else
    logic w_unused_wm_clr;

    assign w_unused_wm_clr = wm_clr_i;
    assign wm_level_o      = '0;
`endif

endmodule

// File: tb/tb_wr_fill_monitor.sv
// tb_wr_fill_monitor: directed bench with a cycle model of the fill monitor plus literal checkpoints.
module tb_wr_fill_monitor;

    localparam int D = 16;
`ifdef WFILL_WATERMARK_EN
    localparam bit WM_EN = 1'b1;
`else
    localparam bit WM_EN = 1'b0;
`endif

    logic       wclk   = 1'b0;
    logic       rst_n  = 1'b0;
    logic [4:0] rptr_g = 5'h1F;
    logic [4:0] wbin   = '0;
    logic [4:0] thresh = '0;
    logic [4:0] hyst   = '0;
    logic       wm_clr = 1'b0;
    logic [4:0] sync2, rbin, wfill, wm;
    logic [1:0] st;
    logic       afull, err;

    int compared   = 0;
    int mismatched = 0;
    int m_s1, m_s2, m_fill, m_state, m_err, m_wm;

    always #5 wclk = ~wclk;

    wr_fill_monitor #(.ADDRSIZE(4)) dut (
        .wclk_i             (wclk),
        .wrst_n_i           (rst_n),
        .rptr_g_i           (rptr_g),
        .wbin_i             (wbin),
        .afull_thresh_i     (thresh),
        .afull_hyst_i       (hyst),
        .wm_clr_i           (wm_clr),
        .rptr_sync2_wrclk_o (sync2),
        .rbin_w_o           (rbin),
        .wfill_o            (wfill),
        .fc_state_o         (st),
        .afull_o            (afull),
        .level_err_o        (err),
        .wm_level_o         (wm)
    );

    function automatic int g2b(int g);
        for (int b = 0; b < 32; b++) if ((b ^ (b >> 1)) == g) return b;
        return 0;
    endfunction

    function automatic logic [4:0] gray(int b);
        return 5'(b ^ (b >> 1));
    endfunction

    // Model: pointer seen two edges late, level as modular distance, FSM as threshold-or-release test.
    always @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_fill = 0; m_state = 0; m_err = 0; m_wm = 0;
        end else begin
            int raw, rel, nstate;
            raw    = (int'(wbin) - g2b(m_s2) + 32) % 32;
            rel    = (thresh > hyst) ? int'(thresh) - int'(hyst) : 0;
            nstate = (m_fill == D) ? 2 :
                     (thresh != 0 && m_fill >= (m_state == 0 ? int'(thresh) : rel)) ? 1 : 0;
            m_wm    = WM_EN ? ((wm_clr || m_fill > m_wm) ? m_fill : m_wm) : 0;
            m_state = nstate;
            m_fill  = (raw > D) ? D : raw;
            if (raw > D) m_err = 1;
            m_s2 = m_s1;
            m_s1 = int'(rptr_g);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge wclk);
        check("sync2", sync2, m_s2);
        check("rbin", rbin, g2b(m_s2));
        check("wfill", wfill, m_fill);
        check("state", st, m_state);
        check("afull", afull, int'(m_state != 0));
        check("err", err, m_err);
        check("wm", wm, m_wm);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    initial begin
        steps(3);
        check("rst_wfill", wfill, 0);
        check("rst_sync2", sync2, 0);
        check("rst_state", st, 0);
        check("rst_afull", afull, 0);
        check("rst_err", err, 0);
        check("rst_wm", wm, 0);
        rst_n = 1'b1;
        step();
        check("rel_sync2_e1", sync2, 0);
        step();
        check("rel_sync2_e2", sync2, 5'h1F);
        check("rel_rbin", rbin, 5'h15);

        rptr_g = 5'h00; wbin = 5'd9;
        steps(4);
        check("lat_pre", wfill, 9);
        rptr_g = 5'h02;
        step(); check("lat_e1", wfill, 9);
        step(); check("lat_e2", wfill, 9); check("lat_sync2", sync2, 2);
        step(); check("lat_e3", wfill, 6);

        thresh = 5'd12; hyst = 5'd4; wbin = 5'd14;
        steps(3);
        check("hy_f11", wfill, 11); check("hy_f11_st", st, 0);
        wbin = 5'd15;
        step(); check("hy_f12", wfill, 12); check("hy_f12_st_lag", st, 0);
        step(); check("hy_f12_st", st, 1); check("hy_f12_afull", afull, 1);
        wbin = 5'd12;
        steps(3); check("hy_f9", wfill, 9); check("hy_f9_st", st, 1);
        wbin = 5'd10;
        step(); check("hy_f7", wfill, 7); check("hy_f7_st_lag", st, 1);
        step(); check("hy_f7_st", st, 0); check("hy_f7_afull", afull, 0);

        wbin = 5'h03; rptr_g = gray(5'h13);
        steps(3); check("full_fill", wfill, 16);
        step(); check("full_st", st, 2);
        rptr_g = gray(5'h14);
        steps(3); check("wrap_fill", wfill, 15); check("wrap_st_lag", st, 2);
        step(); check("wrap_st", st, 1);

        wbin = 5'h00; rptr_g = gray(5);
        steps(3); check("err_fill", wfill, 16); check("err_flag", err, 1);
        wbin = 5'd9;
        steps(4); check("err_fill_ok", wfill, 4); check("err_sticky", err, 1); check("err_st", st, 0);

        #2 rst_n = 1'b0;
        #1;
        check("arst_err", err, 0); check("arst_wfill", wfill, 0);
        check("arst_sync2", sync2, 0); check("arst_st", st, 0); check("arst_wm", wm, 0);
        step();
        rptr_g = 5'h00; wbin = 5'd3; rst_n = 1'b1;
        steps(4); check("wm_f3", wfill, 3);
        wbin = 5'd10; steps(2);
        wbin = 5'd4; steps(2);
        check("wm_peak", wm, WM_EN ? 10 : 0);
        wm_clr = 1'b1;
        step();
        wm_clr = 1'b0;
        check("wm_clr", wm, WM_EN ? 4 : 0);
        step(); check("wm_hold", wm, WM_EN ? 4 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wr_fill_monitor.md
# wr_fill_monitor

Write-clock-domain receiver for the async FIFO read pointer: synchronizes the Gray-coded read pointer into `wclk_i`, decodes it to binary and computes the registered FIFO fill level. It drives a hysteretic almost-full/full flow-control FSM and a sticky pointer-consistency error flag. It sits beside the write-pointer/full block and supplies its synchronized read pointer (`rptr_sync2_wrclk_o`) plus level information for upstream producers.

## Interface
- `ADDRSIZE`, default 4: FIFO address width; depth D = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- `wclk_i`  in  1  write clock.
- `wrst_n_i`  in  1  reset; asynchronous, active-low.
- `rptr_g_i`  in  ADDRSIZE+1  Gray read pointer from the read domain; asynchronous to `wclk_i`.
- `wbin_i`  in  ADDRSIZE+1  registered binary write pointer, `wclk_i` domain.
- `afull_thresh_i`  in  ADDRSIZE+1  almost-full assert level; 0 disables almost-full.
- `afull_hyst_i`  in  ADDRSIZE+1  release hysteresis.
- `wm_clr_i`  in  1  watermark clear strobe.
- `rptr_sync2_wrclk_o`  out  ADDRSIZE+1  2-flop synchronized Gray read pointer.
- `rbin_w_o`  out  ADDRSIZE+1  binary decode of `rptr_sync2_wrclk_o`; combinational.
- `wfill_o`  out  ADDRSIZE+1  registered fill level, 0..D.
- `fc_state_o`  out  2  FSM state: NORMAL=0, AFULL=1, FULL=2.
- `afull_o`  out  1  high whenever state != NORMAL.
- `level_err_o`  out  1  sticky pointer-inconsistency flag.
- `wm_level_o`  out  ADDRSIZE+1  peak fill watermark; see Configuration.

## Operation
- Sync: `rptr_g_i` passes through 2 flops (sync1, sync2). sync2 is `rptr_sync2_wrclk_o`.
- Decode: bit ADDRSIZE is copied; bit i = bit i+1 of binary XOR Gray bit i, down to bit 0.
- Level: raw = (`wbin_i` − `rbin_w_o`) mod 2^(ADDRSIZE+1).
  - raw ≤ D: `wfill_o` <= raw.
  - raw > D: `wfill_o` <= D and `level_err_o` <= 1. The flag stays set until reset.
- Release level: rel = `afull_thresh_i` − `afull_hyst_i`, saturating at 0.
- FSM is evaluated on the registered `wfill_o`. FULL has priority.
  - NORMAL → FULL when wfill == D.
  - NORMAL → AFULL when thresh != 0 and wfill ≥ thresh.
  - AFULL → FULL when wfill == D.
  - AFULL → NORMAL when wfill < rel, or when thresh == 0.
  - FULL → AFULL when wfill < D and thresh != 0 and wfill ≥ rel.
  - FULL → NORMAL when wfill < D and the AFULL condition fails.
- Wrap-around: the extra MSB makes the level correct across pointer wrap. Level D occurs only when the MSBs differ and the lower bits are equal.
- Reset mid-operation clears all state immediately: sync flops, level, FSM, error flag and watermark.

## Timing
- Reset values: all pointer, level and watermark outputs 0; `fc_state_o`=NORMAL; `afull_o`=0; `level_err_o`=0.
- A `rptr_g_i` change appears on `rptr_sync2_wrclk_o` after 2 `wclk_i` edges and on `wfill_o` after 3.
- A `wbin_i` change appears on `wfill_o` after 1 edge.
- `fc_state_o` and `afull_o` lag `wfill_o` by 1 edge.
- Threshold inputs are quasi-static. A change applies to the next FSM evaluation.

## Configuration
- Macro `WFILL_WATERMARK_EN`.
- Defined: `wm_level_o` holds the maximum `wfill_o` since reset or the last clear. It updates 1 edge after `wfill_o`.
  - `wm_clr_i`=1 loads the current `wfill_o`, which also covers a coincident new peak.
- Undefined: no watermark register; `wm_level_o` is tied to 0 and `wm_clr_i` is ignored.

## Structure
- Package `wfill_pkg` holds:
  - `fc_state_e` enum (NORMAL, AFULL, FULL);
  - `WFILL_ADDRSIZE_DEF` = 4;
  - automatic function `gray2bin`, parameterized by width through an unpacked-size argument or a fixed max width with masking.
- One sub-module, `sync2_ff`: a parameterized-width 2-flop synchronizer with asynchronous active-low reset, instantiated for `rptr_g_i`.

## Test plan
- Reset: hold `wrst_n_i`=0 with `rptr_g_i`=0x1F → all outputs 0, NORMAL. After release, `rptr_sync2_wrclk_o`=0x1F on the 2nd edge.
- Latency: ADDRSIZE=4, `wbin_i`=9, `rptr_g_i` changes 0→Gray(3)=0x02 → `wfill_o` goes 9→6 exactly 3 edges later.
- Hysteresis: thresh=12, hyst=4.
  - Sweep fill 11→12 → AFULL 1 edge after `wfill_o`=12.
  - Drop to 9 → stays AFULL.
  - Drop to 7 → NORMAL.
- Full and wrap: `wbin_i`=0x03, read binary=0x13 → `wfill_o`=16, FULL. Read advances to 0x14 → `wfill_o`=15, state goes FULL→AFULL.
- Error: `wbin_i`=0x00, read binary=0x05 (raw 27) → `wfill_o`=16 and `level_err_o`=1. The flag persists after the level returns to normal and clears only on reset.
- Watermark (macro defined): fill 3→10→4 → `wm_level_o`=10. Pulse `wm_clr_i` at fill 4 → `wm_level_o`=4. With the macro undefined, `wm_level_o` stays 0.
